// File: rtl/count_seq_ctrl_if.sv
// count_seq_ctrl_if: control and status bundle for the count sequencer
interface count_seq_ctrl_if #(parameter int WIDTH = 4, parameter int CYCW = 8);
  logic start, halt, abort, mode;
  logic [WIDTH-1:0] limit, q;
  logic busy, done, wrap;
  logic [CYCW-1:0] cyc;
  modport master(output start, halt, abort, mode, limit, input q, busy, done, wrap, cyc);
  modport slave(input start, halt, abort, mode, limit, output q, busy, done, wrap, cyc);
endinterface

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: programmable one-shot/auto-reload counter with halt, resume and abort
module count_seq_ctrl #(parameter int WIDTH = 4, parameter int CYCW = 8) (
  input logic clk,
  input logic rst,
  count_seq_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, FIN = 2'd3;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, lim_q, lim_d;
  logic [CYCW-1:0] cyc_q, cyc_d;
  logic mode_q, mode_d, wrap_q, wrap_d;
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    cyc_d = cyc_q;
    lim_d = lim_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      q_d = '0;
      cyc_d = '0;
    end else if (bus.start && state_q != RUN) begin
      state_d = RUN;
      q_d = '0;
      cyc_d = '0;
      lim_d = bus.limit;
      mode_d = bus.mode;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.halt) state_d = HOLD;
          else if (q_q != lim_q) q_d = q_q + 1'b1;
          else if (!mode_q) state_d = FIN;
          else begin
            q_d = '0;
            wrap_d = 1'b1;
            cyc_d = &cyc_q ? cyc_q : cyc_q + 1'b1;
          end
        end
        HOLD: state_d = bus.halt ? HOLD : RUN;
        FIN: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q <= '0;
      cyc_q <= '0;
      lim_q <= '0;
      mode_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      cyc_q <= cyc_d;
      lim_q <= lim_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.q = q_q;
  assign bus.busy = state_q == RUN || state_q == HOLD;
  assign bus.done = state_q == FIN;
  assign bus.wrap = wrap_q;
  assign bus.cyc = cyc_q;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: vector table, corner sequences and random run against a behavioural model
module tb_count_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  count_seq_ctrl_if #(.WIDTH(4), .CYCW(8)) bus();
  count_seq_ctrl #(.WIDTH(4), .CYCW(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  // behavioural model: what the block is doing, in plain terms
  bit m_counting, m_paused, m_finished, m_mode, m_wrap;
  int m_q, m_lim, m_cyc;

  typedef struct {
    logic s, h, a, m;
    logic [3:0] l;
    int q;
    logic busy, done, wrap;
    int cyc;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_counting = 0; m_paused = 0; m_finished = 0; m_mode = 0; m_wrap = 0;
    m_q = 0; m_lim = 0; m_cyc = 0;
  endtask

  task automatic m_edge(input bit s, input bit h, input bit a, input bit m, input int l);
    bit was_fin = m_finished;
    m_wrap = 0;
    m_finished = 0;
    if (a) begin
      m_counting = 0; m_paused = 0; m_q = 0; m_cyc = 0;
    end else if (s && !(m_counting && !m_paused)) begin
      m_counting = 1; m_paused = 0; m_q = 0; m_cyc = 0; m_lim = l; m_mode = m;
    end else if (m_paused) begin
      m_paused = h;
    end else if (m_counting) begin
      if (h) m_paused = 1;
      else if (m_q < m_lim) m_q++;
      else if (!m_mode) begin
        m_counting = 0; m_finished = 1;
      end else begin
        m_q = 0; m_wrap = 1; m_cyc = (m_cyc == 255) ? 255 : m_cyc + 1;
      end
    end
    if (was_fin && m_finished) m_finished = 0;
  endtask

  task automatic m_check(input string tag);
    chk({tag, ".q"}, bus.q, m_q);
    chk({tag, ".busy"}, bus.busy, m_counting);
    chk({tag, ".done"}, bus.done, m_finished);
    chk({tag, ".wrap"}, bus.wrap, m_wrap);
    chk({tag, ".cyc"}, bus.cyc, m_cyc);
  endtask

  task automatic step(input bit s, input bit h, input bit a, input bit m, input logic [3:0] l, input string tag);
    bus.start = s; bus.halt = h; bus.abort = a; bus.mode = m; bus.limit = l;
    @(posedge clk);
    m_edge(s, h, a, m, int'(l));
    #1;
    m_check(tag);
  endtask

  initial begin
    bus.start = 0; bus.halt = 0; bus.abort = 0; bus.mode = 0; bus.limit = '0;
    m_reset();
    // s h a m l   q busy done wrap cyc
    vecs[0]  = '{1,0,0,0,4'd2, 0,1,0,0,0};
    vecs[1]  = '{0,0,0,0,4'd9, 1,1,0,0,0};
    vecs[2]  = '{0,0,0,0,4'd0, 2,1,0,0,0};
    vecs[3]  = '{0,0,0,0,4'd0, 2,0,1,0,0};
    vecs[4]  = '{0,0,0,0,4'd0, 2,0,0,0,0};
    vecs[5]  = '{1,0,0,1,4'd1, 0,1,0,0,0};
    vecs[6]  = '{0,0,0,0,4'd0, 1,1,0,0,0};
    vecs[7]  = '{0,0,0,0,4'd0, 0,1,0,1,1};
    vecs[8]  = '{0,0,0,0,4'd0, 1,1,0,0,1};
    vecs[9]  = '{0,1,0,0,4'd0, 1,1,0,0,1};
    vecs[10] = '{0,0,0,0,4'd0, 1,1,0,0,1};
    vecs[11] = '{0,0,0,0,4'd0, 0,1,0,1,2};
    vecs[12] = '{1,1,1,0,4'd5, 0,0,0,0,0};
    #12;
    chk("reset.q", bus.q, 0); chk("reset.busy", bus.busy, 0);
    chk("reset.done", bus.done, 0); chk("reset.wrap", bus.wrap, 0); chk("reset.cyc", bus.cyc, 0);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].s, vecs[i].h, vecs[i].a, vecs[i].m, vecs[i].l, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.q", i), bus.q, vecs[i].q);
      chk($sformatf("tbl%0d.busy", i), bus.busy, vecs[i].busy);
      chk($sformatf("tbl%0d.done", i), bus.done, vecs[i].done);
      chk($sformatf("tbl%0d.wrap", i), bus.wrap, vecs[i].wrap);
      chk($sformatf("tbl%0d.cyc", i), bus.cyc, vecs[i].cyc);
    end
    // LIMIT=0 one-shot, START ignored in RUN, START in FIN restarts
    step(1, 0, 0, 0, 4'd0, "l0.start");
    step(0, 0, 0, 0, 4'd0, "l0.fin");
    chk("l0.done", bus.done, 1);
    step(1, 0, 0, 0, 4'd3, "fin.restart");
    chk("fin.restart.q", bus.q, 0); chk("fin.restart.busy", bus.busy, 1);
    step(0, 0, 0, 0, 4'd0, "r1");
    step(1, 0, 0, 0, 4'd7, "run.start");
    chk("run.start.ignored", bus.q, 2);
    step(0, 0, 0, 0, 4'd0, "r3");
    step(0, 0, 0, 0, 4'd0, "r4");
    chk("newlim.fin", bus.done, 1);
    // HALT in the middle of a count delays completion by one cycle per HALT plus resume
    step(1, 0, 0, 0, 4'd9, "h.start");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'd0, "h.cnt");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'd0, "h.hold");
    chk("h.held", bus.q, 4);
    step(0, 0, 0, 0, 4'd0, "h.resume");
    chk("h.resume.q", bus.q, 4);
    step(0, 0, 0, 0, 4'd0, "h.next");
    chk("h.next.q", bus.q, 5);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 4'd0, "h.tail");
    chk("h.done", bus.done, 1);
    // wrap counter saturation with one-cycle period
    step(1, 0, 0, 1, 4'd0, "sat.start");
    for (int i = 0; i < 260; i++) step(0, 0, 0, 0, 4'd0, "sat");
    chk("sat.cyc", bus.cyc, 255); chk("sat.wrap", bus.wrap, 1);
    // asynchronous reset between edges
    step(1, 0, 0, 1, 4'd2, "ar.start");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'd0, "ar.run");
    #2 rst = 1'b1;
    #1;
    chk("ar.q", bus.q, 0); chk("ar.busy", bus.busy, 0); chk("ar.cyc", bus.cyc, 0);
    m_reset();
    #1 rst = 1'b0;
    step(0, 0, 0, 0, 4'd0, "ar.idle");
    // random run against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
           1'($urandom), 4'($urandom), "rnd");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
